// File: rtl/reg_file_loader.sv
// -----------------------------------------------------------------------------
// reg_file_loader
//
// Purpose
//   Loads a contiguous, wrapping run of 1..8 registers of an 8x8 register file
//   from an upstream data stream, then reads every loaded register back and
//   compares it with a private shadow copy of what was written. A job ends
//   with a one-cycle DONE pulse. The first mismatching register is reported
//   through the sticky ERROR/ERRREG pair.
//
// Ports
//   CLK          in   1  clock; all state changes on the rising edge
//   RESET        in   1  synchronous, active-high reset
//   START        in   1  job request, honoured only while idle
//   BASEREG      in   3  first register index of the job (captured with START)
//   COUNT        in   3  job length minus one (captured with START)
//   DATA_IN      in   8  stream data word
//   DATA_VALID   in   1  DATA_IN is valid
//   DATA_READY   out  1  loader accepts DATA_IN this cycle
//   WRITEREG     out  3  register file write index   (registered)
//   WRITEDATA    out  8  register file write data    (registered)
//   WRITEENABLE  out  1  register file write strobe  (registered)
//   READREG1     out  3  register file read index    (registered)
//   REGOUT1      in   8  register file read data, combinational from READREG1
//   BUSY         out  1  high whenever the loader is not idle
//   DONE         out  1  one-cycle pulse in the final cycle of a job
//   ERROR        out  1  readback mismatch, sticky until next START or RESET
//   ERRREG       out  3  register index of the first mismatch
//   DBG_STATE    out  3  current FSM state encoding, for observation only
//
// Stream handshake
//   A word moves from the stream into the loader in exactly those cycles where
//   DATA_VALID and DATA_READY are both 1 at the rising edge. DATA_READY is high
//   only in the WRITE state and never depends on DATA_VALID. The producer may
//   hold DATA_VALID low for any number of cycles; the loader simply waits.
//
// Timing of one job (continuous DATA_VALID, COUNT = n-1)
//   n WRITE cycles, 1 DRAIN cycle, 2n verify cycles (VADDR/VCHK pairs), 1 FIN.
// -----------------------------------------------------------------------------
module reg_file_loader (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [2:0] BASEREG,
  input  logic [2:0] COUNT,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  output logic       DATA_READY,
  output logic [2:0] WRITEREG,
  output logic [7:0] WRITEDATA,
  output logic       WRITEENABLE,
  output logic [2:0] READREG1,
  input  logic [7:0] REGOUT1,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  output logic [2:0] ERRREG,
  output logic [2:0] DBG_STATE
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_VADDR = 3'd3,
    ST_VCHK  = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

  state_e      state_q,  state_d;
  logic [2:0]  base_q,   base_d;
  logic [2:0]  count_q,  count_d;
  logic [2:0]  idx_q,    idx_d;
  logic        we_q,     we_d;
  logic [2:0]  wreg_q,   wreg_d;
  logic [7:0]  wdata_q,  wdata_d;
  logic [2:0]  rreg_q,   rreg_d;
  logic        err_q,    err_d;
  logic [2:0]  errreg_q, errreg_d;

  // Copy of every word written during the current job, indexed by position
  // in the job (not by register index), used as the readback reference.
  logic [7:0]  shadow_q [8];
  logic [7:0]  shadow_d [8];

  // Register index addressed by the current job position; 3-bit addition
  // gives the modulo-8 wrap for free.
  logic [2:0]  cur_reg;
  logic        last_pos;
  logic        transfer;

  assign cur_reg  = base_q + idx_q;
  assign last_pos = (idx_q == count_q);

  // A stream word is consumed only while writing, and only when offered.
  assign transfer = (state_q == ST_WRITE) && DATA_VALID;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    idx_d    = idx_q;
    we_d     = 1'b0;      // the write strobe only follows a transfer
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    rreg_d   = rreg_q;    // read index holds outside the verify pass
    err_d    = err_q;
    errreg_d = errreg_q;
    shadow_d = shadow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          base_d   = BASEREG;
          count_d  = COUNT;
          idx_d    = 3'd0;
          err_d    = 1'b0;
          errreg_d = 3'd0;
          state_d  = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (transfer) begin
          we_d             = 1'b1;
          wreg_d           = cur_reg;
          wdata_d          = DATA_IN;
          shadow_d[idx_q]  = DATA_IN;
          idx_d            = idx_q + 3'd1;
          if (last_pos) begin
            state_d = ST_DRAIN;
          end
        end
      end

      // The final write strobe is visible during this cycle and lands in the
      // register file at its closing edge, so the verify pass starts after it.
      ST_DRAIN: begin
        idx_d   = 3'd0;
        state_d = ST_VADDR;
      end

      // Present the read index; REGOUT1 is looked at one cycle later so the
      // comparison always sees a registered, stable address.
      ST_VADDR: begin
        rreg_d  = cur_reg;
        state_d = ST_VCHK;
      end

      ST_VCHK: begin
        if (REGOUT1 != shadow_q[idx_q]) begin
          err_d    = 1'b1;
          errreg_d = cur_reg;
          state_d  = ST_FIN;
        end else if (last_pos) begin
          state_d  = ST_FIN;
        end else begin
          idx_d    = idx_q + 3'd1;
          state_d  = ST_VADDR;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset wins over START and over any transfer in the same
  // cycle. The shadow store is never read before it is written within a job,
  // so it is left out of reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      base_q   <= 3'd0;
      count_q  <= 3'd0;
      idx_q    <= 3'd0;
      we_q     <= 1'b0;
      wreg_q   <= 3'd0;
      wdata_q  <= 8'd0;
      rreg_q   <= 3'd0;
      err_q    <= 1'b0;
      errreg_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      rreg_q   <= rreg_d;
      err_q    <= err_d;
      errreg_q <= errreg_d;
      shadow_q <= shadow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign DATA_READY  = (state_q == ST_WRITE);
  assign BUSY        = (state_q != ST_IDLE);
  assign DONE        = (state_q == ST_FIN);
  assign WRITEENABLE = we_q;
  assign WRITEREG    = wreg_q;
  assign WRITEDATA   = wdata_q;
  assign READREG1    = rreg_q;
  assign ERROR       = err_q;
  assign ERRREG      = errreg_q;
  assign DBG_STATE   = state_q;

endmodule

// File: doc/reg_file_loader.md
REG_FILE_LOADER -- requirements
Module: reg_file_loader

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-003 SHALL have port START  input  1  one-cycle request to begin a load-and-verify job; sampled only in IDLE.
REQ-004 SHALL have port BASEREG  input  3  first register index of the job; captured with START.
REQ-005 SHALL have port COUNT  input  3  job length minus one (0 means 1 register, 7 means 8); captured with START.
REQ-006 SHALL have port DATA_IN  input  8  write data word from the upstream stream.
REQ-007 SHALL have port DATA_VALID  input  1  DATA_IN is valid.
REQ-008 SHALL have port DATA_READY  output  1  loader accepts DATA_IN this cycle.
REQ-009 SHALL have port WRITEREG  output  3  register file write index.
REQ-010 SHALL have port WRITEDATA  output  8  register file write data.
REQ-011 SHALL have port WRITEENABLE  output  1  register file write strobe; the register file commits on the next rising CLK.
REQ-012 SHALL have port READREG1  output  3  register file read index for readback.
REQ-013 SHALL have port REGOUT1  input  8  register file read data, combinational from READREG1.
REQ-014 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-015 SHALL have port DONE  output  1  one-cycle pulse at job end.
REQ-016 SHALL have port ERROR  output  1  readback mismatch flag; sticky until the next accepted START or RESET.
REQ-017 SHALL have port ERRREG  output  3  index of the first mismatching register; valid while ERROR=1.

Function
REQ-018 SHALL implement states IDLE, WRITE, DRAIN, VADDR, VCHK, FIN.
REQ-019 IDLE: START=1 SHALL capture BASEREG/COUNT, clear ERROR and ERRREG, zero the index counter i, and go to WRITE next cycle; START in any other state SHALL be ignored.
REQ-020 WRITE: DATA_READY SHALL be 1; a transfer occurs only in a cycle with DATA_VALID=1 and DATA_READY=1.
REQ-021 Each transfer SHALL, registered at that rising edge, drive WRITEENABLE=1, WRITEREG=(base+i) mod 8, WRITEDATA=DATA_IN, store DATA_IN in an internal 8x8 shadow entry i, and increment i.
REQ-022 WRITEENABLE SHALL be 0 in any cycle that does not follow a transfer; back-to-back transfers SHALL produce back-to-back writes (1 word per cycle).
REQ-023 The transfer with i=COUNT SHALL move WRITE->DRAIN; DATA_READY SHALL be 0 from the next cycle.
REQ-024 DRAIN: single cycle in which the final write commits; then i SHALL reset to 0 and go to VADDR.
REQ-025 VADDR: READREG1 SHALL be driven (registered) to (base+i) mod 8; next state VCHK.
REQ-026 VCHK: REGOUT1 SHALL be compared with shadow entry i; on mismatch, set ERROR=1, ERRREG=(base+i) mod 8, and go to FIN; on match with i=COUNT go to FIN; otherwise increment i and go to VADDR.
REQ-027 Readback latency SHALL be exactly 2 cycles per register; a full 8-register job SHALL take 8 write cycles + 1 DRAIN + 16 verify cycles + 1 FIN with continuous DATA_VALID.
REQ-028 FIN: DONE=1 for exactly one cycle; next state IDLE.
REQ-029 Register index SHALL wrap modulo 8 (BASEREG=6, COUNT=3 writes regs 6,7,0,1).
REQ-030 DATA_VALID low in WRITE SHALL stall without timeout; no state change, no write.
REQ-031 READREG1 SHALL hold its last value outside VADDR/VCHK.

Reset
REQ-032 RESET=1 at a rising edge SHALL force IDLE and DATA_READY=0, WRITEENABLE=0, WRITEREG=0, WRITEDATA=0, READREG1=0, BUSY=0, DONE=0, ERROR=0, ERRREG=0, i=0.
REQ-033 RESET SHALL take priority over START and any transfer in the same cycle; a job interrupted mid-operation SHALL be abandoned without DONE, and writes already issued SHALL not be undone.

Verification
REQ-034 BASEREG=2, COUNT=0, DATA_IN=95 -> one write reg2=95, readback match, DONE pulse, ERROR=0, BUSY low after FIN.
REQ-035 BASEREG=6, COUNT=3, data 1,2,3,4 continuous -> WRITEREG sequence 6,7,0,1 on consecutive cycles, DONE 13 cycles after first transfer, ERROR=0.
REQ-036 BASEREG=0, COUNT=7, DATA_VALID toggling every other cycle -> 8 writes, no WRITEENABLE in stall cycles, all 8 readbacks match.
REQ-037 BASEREG=4, COUNT=1, data 6,15; bench forces REGOUT1 corrupt on reg5 -> ERROR=1, ERRREG=5, DONE pulse; ERROR clears on next START.
REQ-038 RESET asserted after 2nd transfer of COUNT=7 job -> next cycle all outputs 0, IDLE, no DONE; START then accepted normally.
REQ-039 START asserted while BUSY=1 -> ignored, running job completes unchanged.
